// File: rtl/wb_arb2_sdram.sv
// Two-master Wishbone B3 round-robin arbiter in front of the SDR SDRAM controller's slave port.
// Latency: one cycle to arbitrate from IDLE; request, data and ack paths are combinational once granted.
// Backpressure: grant is held through stb gaps and ack waits until the final beat (or cyc drop).
module wb_arb2_sdram #(
  parameter int adr_size = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         m0_dat_i,
  input  logic [adr_size:1]   m0_adr_i,
  input  logic [3:0]          m0_sel_i,
  input  logic [2:0]          m0_cti_i,
  input  logic [1:0]          m0_bte_i,
  input  logic                m0_we_i,
  input  logic                m0_cyc_i,
  input  logic                m0_stb_i,
  output logic [31:0]         m0_dat_o,
  output logic                m0_ack_o,
  input  logic [31:0]         m1_dat_i,
  input  logic [adr_size:1]   m1_adr_i,
  input  logic [3:0]          m1_sel_i,
  input  logic [2:0]          m1_cti_i,
  input  logic [1:0]          m1_bte_i,
  input  logic                m1_we_i,
  input  logic                m1_cyc_i,
  input  logic                m1_stb_i,
  output logic [31:0]         m1_dat_o,
  output logic                m1_ack_o,
  output logic [31:0]         s_dat_o,
  output logic [adr_size:1]   s_adr_o,
  output logic [3:0]          s_sel_o,
  output logic [2:0]          s_cti_o,
  output logic [1:0]          s_bte_o,
  output logic                s_we_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  input  logic [31:0]         s_dat_i,
  input  logic                s_ack_i
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state;
  state_t state_nxt;
  logic   last;   // 1 = m1 was granted most recently
  logic   req0;
  logic   req1;
  logic   done0;
  logic   done1;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  // A grant ends when the owner drops cyc, or on the ack of a classic / end-of-burst beat
  assign done0 = ~m0_cyc_i | (s_ack_i & ((m0_cti_i == 3'b000) | (m0_cti_i == 3'b111)));
  assign done1 = ~m1_cyc_i | (s_ack_i & ((m1_cti_i == 3'b000) | (m1_cti_i == 3'b111)));

  // Read data is broadcast; only ack is steered
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // State register and round-robin priority bit, updated when a grant is released
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == GNT0 && state_nxt == IDLE) begin
        last <= 1'b0;
      end else if (state == GNT1 && state_nxt == IDLE) begin
        last <= 1'b1;
      end
    end
  end

  // Next-state arbitration and slave-side request mux
  always_comb begin
    state_nxt = state;
    s_dat_o   = m0_dat_i;
    s_adr_o   = m0_adr_i;
    s_sel_o   = m0_sel_i;
    s_cti_o   = m0_cti_i;
    s_bte_o   = m0_bte_i;
    s_we_o    = 1'b0;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    m0_ack_o  = 1'b0;
    m1_ack_o  = 1'b0;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          state_nxt = last ? GNT0 : GNT1;
        end else if (req0) begin
          state_nxt = GNT0;
        end else if (req1) begin
          state_nxt = GNT1;
        end
      end
      GNT0: begin
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        m0_ack_o = s_ack_i;
        if (done0) begin
          state_nxt = IDLE;
        end
      end
      GNT1: begin
        s_dat_o  = m1_dat_i;
        s_adr_o  = m1_adr_i;
        s_sel_o  = m1_sel_i;
        s_cti_o  = m1_cti_i;
        s_bte_o  = m1_bte_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        m1_ack_o = s_ack_i;
        if (done1) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_arb2_sdram.sv
// Directed bench for the two-master Wishbone arbiter.
// Inputs driven 1 ns after the rising edge, outputs sampled 2 ns later.
// Each scenario task performs its own inline comparisons.
module tb_wb_arb2_sdram;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] m0_dat_i = '0, m1_dat_i = '0;
  logic [24:1] m0_adr_i = '0, m1_adr_i = '0;
  logic [3:0]  m0_sel_i = '0, m1_sel_i = '0;
  logic [2:0]  m0_cti_i = '0, m1_cti_i = '0;
  logic [1:0]  m0_bte_i = '0, m1_bte_i = '0;
  logic        m0_we_i = 1'b0, m1_we_i = 1'b0;
  logic        m0_cyc_i = 1'b0, m1_cyc_i = 1'b0;
  logic        m0_stb_i = 1'b0, m1_stb_i = 1'b0;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m1_ack_o;
  logic [31:0] s_dat_o;
  logic [24:1] s_adr_o;
  logic [3:0]  s_sel_o;
  logic [2:0]  s_cti_o;
  logic [1:0]  s_bte_o;
  logic        s_we_o, s_cyc_o, s_stb_o;
  logic [31:0] s_dat_i = '0;
  logic        s_ack_i = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arb2_sdram #(.adr_size(24)) dut (
    .clk(clk), .rst(rst),
    .m0_dat_i(m0_dat_i), .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_cti_i(m0_cti_i),
    .m0_bte_i(m0_bte_i), .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m1_dat_i(m1_dat_i), .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_cti_i(m1_cti_i),
    .m1_bte_i(m1_bte_i), .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .s_dat_o(s_dat_o), .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o),
    .s_bte_o(s_bte_o), .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  // advance to 1 ns after the next rising edge (input drive point)
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    nxt();
    nxt();
    s_ack_i = 1'b1;
    #2;
    checks++;
    if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || s_we_o !== 1'b0) begin
      errors++; $display("FAIL reset_s_ctrl got cyc=%b stb=%b we=%b exp 0 0 0", s_cyc_o, s_stb_o, s_we_o);
    end
    checks++;
    if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) begin
      errors++; $display("FAIL reset_ack got m0=%b m1=%b exp 0 0", m0_ack_o, m1_ack_o);
    end
    nxt();
    rst = 1'b0;
    s_ack_i = 1'b0;
  endtask

  task automatic test_classic_write();
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_adr_i = 24'h000010;
    m0_dat_i = 32'hDEADBEEF; m0_sel_i = 4'hF; m0_cti_i = 3'b000;
    s_ack_i = 1'b1;   // stray ack while idle must not reach anyone
    #2;
    checks++;
    if (s_cyc_o !== 1'b0 || m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) begin
      errors++; $display("FAIL cw_arb_cycle got cyc=%b ack0=%b ack1=%b exp 0 0 0", s_cyc_o, m0_ack_o, m1_ack_o);
    end
    s_ack_i = 1'b0;
    nxt();
    #2;
    checks++;
    if (s_cyc_o !== 1'b1 || s_stb_o !== 1'b1 || s_we_o !== 1'b1 || s_dat_o !== 32'hDEADBEEF ||
        s_adr_o !== 24'h000010 || s_sel_o !== 4'hF) begin
      errors++; $display("FAIL cw_grant got cyc=%b stb=%b we=%b dat=%h adr=%h sel=%h exp 1 1 1 deadbeef 000010 f",
                         s_cyc_o, s_stb_o, s_we_o, s_dat_o, s_adr_o, s_sel_o);
    end
    s_ack_i = 1'b1;
    #1;
    checks++;
    if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin
      errors++; $display("FAIL cw_ack got m0=%b m1=%b exp 1 0", m0_ack_o, m1_ack_o);
    end
    nxt();
    s_ack_i = 1'b0;
    #2;
    checks++;
    if (s_cyc_o !== 1'b0 || m0_ack_o !== 1'b0) begin
      errors++; $display("FAIL cw_idle_after got cyc=%b ack0=%b exp 0 0 (master still holds cyc)", s_cyc_o, m0_ack_o);
    end
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
    nxt();
  endtask

  task automatic test_tie_after_reset();
    rst = 1'b1;
    nxt();
    nxt();
    rst = 1'b0;
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 24'h000100; m0_cti_i = 3'b000;
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_adr_i = 24'h000200; m1_cti_i = 3'b000;
    nxt();
    #2;
    checks++;
    if (s_cyc_o !== 1'b1 || s_adr_o !== 24'h000100) begin
      errors++; $display("FAIL tie_first got cyc=%b adr=%h exp 1 000100", s_cyc_o, s_adr_o);
    end
    s_ack_i = 1'b1; s_dat_i = 32'h12345678;
    #1;
    checks++;
    if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0 || m0_dat_o !== 32'h12345678 || m1_dat_o !== 32'h12345678) begin
      errors++; $display("FAIL tie_ack0 got ack0=%b ack1=%b d0=%h d1=%h exp 1 0 12345678 12345678",
                         m0_ack_o, m1_ack_o, m0_dat_o, m1_dat_o);
    end
    nxt();
    s_ack_i = 1'b0; m0_cyc_i = 0; m0_stb_i = 0;
    #2;
    checks++;
    if (s_cyc_o !== 1'b0) begin
      errors++; $display("FAIL tie_idle got cyc=%b exp 0", s_cyc_o);
    end
    nxt();
    #2;
    checks++;
    if (s_cyc_o !== 1'b1 || s_adr_o !== 24'h000200) begin
      errors++; $display("FAIL tie_second got cyc=%b adr=%h exp 1 000200", s_cyc_o, s_adr_o);
    end
    s_ack_i = 1'b1;
    #1;
    checks++;
    if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin
      errors++; $display("FAIL tie_ack1 got ack0=%b ack1=%b exp 0 1", m0_ack_o, m1_ack_o);
    end
    nxt();
    s_ack_i = 1'b0; m1_cyc_i = 0; m1_stb_i = 0;
    nxt();
  endtask

  task automatic test_read_burst_hold();
    logic [24:1] exp_adr;
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 24'h000040; m0_cti_i = 3'b010; m0_bte_i = 2'b01;
    nxt();
    s_ack_i = 1'b1;
    for (int b = 0; b < 4; b++) begin
      exp_adr = 24'h000040 + 24'(b);
      m0_adr_i = exp_adr;
      m0_cti_i = (b == 3) ? 3'b111 : 3'b010;
      if (b == 1) begin
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_adr_i = 24'h000300; m1_cti_i = 3'b000;
      end
      #2;
      checks++;
      if (s_cyc_o !== 1'b1 || s_adr_o !== exp_adr || s_bte_o !== 2'b01 || m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin
        errors++; $display("FAIL burst_beat%0d got cyc=%b adr=%h bte=%b ack0=%b ack1=%b exp 1 %h 01 1 0",
                           b, s_cyc_o, s_adr_o, s_bte_o, m0_ack_o, m1_ack_o, exp_adr);
      end
      nxt();
    end
    s_ack_i = 1'b0; m0_cyc_i = 0; m0_stb_i = 0; m0_cti_i = 3'b000; m0_bte_i = 2'b00;
    #2;
    checks++;
    if (s_cyc_o !== 1'b0 || m1_ack_o !== 1'b0) begin
      errors++; $display("FAIL burst_release got cyc=%b ack1=%b exp 0 0", s_cyc_o, m1_ack_o);
    end
    nxt();
    #2;
    checks++;
    if (s_cyc_o !== 1'b1 || s_adr_o !== 24'h000300) begin
      errors++; $display("FAIL burst_m1_grant got cyc=%b adr=%h exp 1 000300", s_cyc_o, s_adr_o);
    end
    s_ack_i = 1'b1;
    nxt();
    s_ack_i = 1'b0; m1_cyc_i = 0; m1_stb_i = 0;
    nxt();
  endtask

  task automatic test_cyc_drop();
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 24'h000500; m1_cti_i = 3'b010;
    nxt();
    #2;
    checks++;
    if (s_cyc_o !== 1'b1 || s_adr_o !== 24'h000500) begin
      errors++; $display("FAIL drop_grant got cyc=%b adr=%h exp 1 000500", s_cyc_o, s_adr_o);
    end
    nxt();
    m1_cyc_i = 0; m1_stb_i = 0;
    nxt();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 24'h000600; m0_cti_i = 3'b000;
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 24'h000700; m1_cti_i = 3'b000;
    #2;
    checks++;
    if (s_cyc_o !== 1'b0) begin
      errors++; $display("FAIL drop_idle got cyc=%b exp 0", s_cyc_o);
    end
    nxt();
    #2;
    checks++;
    if (s_cyc_o !== 1'b1 || s_adr_o !== 24'h000600) begin
      errors++; $display("FAIL drop_tie got cyc=%b adr=%h exp 1 000600", s_cyc_o, s_adr_o);
    end
    s_ack_i = 1'b1;
    nxt();
    s_ack_i = 1'b0; m0_cyc_i = 0; m0_stb_i = 0;
    nxt();
    s_ack_i = 1'b1;
    nxt();
    s_ack_i = 1'b0; m1_cyc_i = 0; m1_stb_i = 0;
    nxt();
  endtask

  task automatic test_write_stall();
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_adr_i = 24'h000080; m0_dat_i = 32'h0000_0001;
    m0_cti_i = 3'b010; m0_bte_i = 2'b01;
    nxt();
    s_ack_i = 1'b1;
    #2;
    checks++;
    if (m0_ack_o !== 1'b1 || s_stb_o !== 1'b1) begin
      errors++; $display("FAIL stall_beat0 got ack0=%b stb=%b exp 1 1", m0_ack_o, s_stb_o);
    end
    nxt();
    s_ack_i = 1'b0; m0_stb_i = 0; m0_adr_i = 24'h000081; m0_dat_i = 32'h0000_0002;
    for (int g = 0; g < 3; g++) begin
      #2;
      checks++;
      if (s_cyc_o !== 1'b1 || s_stb_o !== 1'b0 || s_adr_o !== 24'h000081 || s_we_o !== 1'b1) begin
        errors++; $display("FAIL stall_gap%0d got cyc=%b stb=%b adr=%h we=%b exp 1 0 000081 1",
                           g, s_cyc_o, s_stb_o, s_adr_o, s_we_o);
      end
      nxt();
    end
    m0_stb_i = 1; s_ack_i = 1'b1;
    for (int b = 1; b < 4; b++) begin
      m0_adr_i = 24'h000080 + 24'(b);
      m0_dat_i = 32'(b + 1);
      m0_cti_i = (b == 3) ? 3'b111 : 3'b010;
      #2;
      checks++;
      if (s_cyc_o !== 1'b1 || s_dat_o !== 32'(b + 1) || m0_ack_o !== 1'b1) begin
        errors++; $display("FAIL stall_beat%0d got cyc=%b dat=%h ack0=%b exp 1 %h 1", b, s_cyc_o, s_dat_o, m0_ack_o, 32'(b + 1));
      end
      nxt();
    end
    s_ack_i = 1'b0; m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_cti_i = 3'b000; m0_bte_i = 2'b00;
    #2;
    checks++;
    if (s_cyc_o !== 1'b0) begin
      errors++; $display("FAIL stall_done got cyc=%b exp 0", s_cyc_o);
    end
    nxt();
  endtask

  task automatic test_reset_mid_burst();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 24'h000900; m0_cti_i = 3'b000;
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 24'h000A00; m1_cti_i = 3'b010;
    nxt();
    #2;
    checks++;
    if (s_cyc_o !== 1'b1 || s_adr_o !== 24'h000A00) begin
      errors++; $display("FAIL rstb_tie_m1 got cyc=%b adr=%h exp 1 000a00", s_cyc_o, s_adr_o);
    end
    s_ack_i = 1'b1;
    nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    #2;
    checks++;
    if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || m1_ack_o !== 1'b0 || m0_ack_o !== 1'b0) begin
      errors++; $display("FAIL rstb_abandon got cyc=%b stb=%b ack1=%b ack0=%b exp 0 0 0 0",
                         s_cyc_o, s_stb_o, m1_ack_o, m0_ack_o);
    end
    s_ack_i = 1'b0;
    nxt();
    #2;
    checks++;
    if (s_cyc_o !== 1'b1 || s_adr_o !== 24'h000900) begin
      errors++; $display("FAIL rstb_tie_m0 got cyc=%b adr=%h exp 1 000900", s_cyc_o, s_adr_o);
    end
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    nxt();
  endtask

  initial begin
    #1;
    test_reset();
    test_classic_write();
    test_tie_after_reset();
    test_read_burst_hold();
    test_cyc_drop();
    test_write_stall();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
